ldw_fetch_ctrl: RTL
===================

LDW_FETCH_CTRL -- requirements
Module: ldw_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset and on IDLE->RUN.
REQ-002 Parameter DELAY_SLOT, default 1; 1 = MIPS delay slot, flush never asserted; 0 = flush on redirect.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 clrn  in  1  asynchronous active-low reset.
REQ-005 run  in  1  level; request to execute from instruction memory.
REQ-006 stall  in  1  hazard hold from decode; freezes PC.
REQ-007 pcsource  in  2  next-PC select: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
REQ-008 bpc, rpc, jpc  in  32 each  branch, register and jump targets.
REQ-009 ld_req  in  1  loader request to write instruction memory.
REQ-010 ld_addr, ld_data  in  32 each  loader write address and data.
REQ-011 ld_gnt  out  1  loader grant; registered.
REQ-012 pc  out  32  current fetch PC; registered.
REQ-013 imem_addr  out  32  instruction memory address.
REQ-014 imem_we, imem_wdata  out  1, 32  instruction memory write enable and data.
REQ-015 fetch_valid  out  1  fetched instruction at pc is valid this cycle.
REQ-016 flush  out  1  kill the instruction in IF/ID.
REQ-017 fetch_cnt  out  32  count of accepted fetches.
REQ-018 state  out  2  FSM state: IDLE=00, LOAD=01, RUN=10.

Function
REQ-019 IDLE: ld_req=1 -> LOAD; else run=1 -> RUN with pc<=RESET_PC; ld_req takes priority over run.
REQ-020 LOAD: ld_gnt=1; ld_req=0 -> IDLE with ld_gnt<=0 next edge; run is ignored in LOAD.
REQ-021 Loader handshake: a write occurs in each cycle where ld_req&&ld_gnt; imem_we=ld_req&&ld_gnt (combinational), imem_wdata=ld_data, imem_addr={ld_addr[31:2],2'b00}.
REQ-022 Outside LOAD: imem_addr=pc, imem_we=0, imem_wdata=0.
REQ-023 RUN, run=0 -> IDLE next edge; pc is retained, fetch_valid=0 from that edge.
REQ-024 RUN: ld_req is ignored and ld_gnt stays 0.
REQ-025 fetch_valid=1 exactly while state==RUN.
REQ-026 RUN with stall=0: pc<=npc, where npc=pc+4 / bpc / rpc / jpc per pcsource; fetch_cnt<=fetch_cnt+1.
REQ-027 RUN with stall=1: pc and fetch_cnt hold; stall overrides any pcsource value in the same cycle.
REQ-028 Targets are word-aligned: npc[1:0] is forced to 00, so pc[1:0] is always 00.
REQ-029 Arithmetic is modulo 2^32: pc=32'hFFFF_FFFC with pcsource=00 -> 32'h0000_0000; fetch_cnt wraps FFFF_FFFF -> 0.
REQ-030 flush = (DELAY_SLOT==0) && RUN && !stall && pcsource!=00; combinational, same cycle as redirect.
REQ-031 Next-PC selection reacts to pcsource and targets within the same cycle (no added latency); pc updates one edge later.

Reset
REQ-032 clrn=0 asynchronously forces state=IDLE, pc=RESET_PC, ld_gnt=0, fetch_cnt=0.
REQ-033 While clrn=0: imem_we=0, flush=0, fetch_valid=0.
REQ-034 Reset mid-LOAD aborts the transfer; no write occurs once clrn is low.
REQ-035 Reset mid-RUN discards the redirect pending in that cycle.
REQ-036 First edge after clrn rises evaluates IDLE transitions normally.

Structure
REQ-037 Shared package ldw_cpu_pkg holds the state encodings, pcsource encodings (PCS_SEQ, PCS_BR, PCS_REG, PCS_JMP) and the default RESET_PC constant.
REQ-038 One combinational sub-module, ldw_npc_mux (pc4/bpc/rpc/jpc select plus alignment), is instantiated.
REQ-039 FSM, PC register, counter and memory-port arbitration live in ldw_fetch_ctrl.

Verification
REQ-040 Load: reset, ld_req=1 for 3 cycles with addr 0,4,8 and data A,B,C -> ld_gnt=1 from cycle 2; imem_we pulses at the granted beats; IDLE after ld_req drops.
REQ-041 Sequential fetch: run=1, pcsource=00, stall=0 for 4 cycles -> pc 0,4,8,C, fetch_cnt=4.
REQ-042 Branch redirect: in RUN at pc=8, pcsource=01, bpc=32'h40 -> next pc=40; with DELAY_SLOT=0, flush=1 in that cycle; with default, flush=0.
REQ-043 Stall and redirect together: stall=1, pcsource=11, jpc=100 -> pc and fetch_cnt hold; on stall release, pc=100.
REQ-044 Wrap: pc forced to FFFF_FFFC, pcsource=00 -> pc=0; misaligned jpc=32'h103 -> pc=100.
REQ-045 Async reset: clrn low mid-LOAD and mid-RUN, asynchronously to clk -> immediate IDLE, pc=RESET_PC, imem_we=0, fetch_cnt=0.

Source files
------------

// File: rtl/ldw_cpu_pkg.sv
// Shared encodings for the ldw fetch path: FSM states, next-PC selects
// and the default reset PC.
package ldw_cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00,
    PCS_BR  = 2'b01,
    PCS_REG = 2'b10,
    PCS_JMP = 2'b11
  } pcsource_e;

  localparam logic [31:0] LDW_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/ldw_npc_mux.sv
// Next-PC selector: sequential, branch, register or jump target, with the
// result forced onto a word boundary.
module ldw_npc_mux
  import ldw_cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic [31:0] npc
);

  logic [31:0] sel;

  // Pick the target, then clear the byte-offset bits.
  always_comb begin
    sel = pc + 32'd4;
    case (pcsource)
      PCS_SEQ: sel = pc + 32'd4;
      PCS_BR:  sel = bpc;
      PCS_REG: sel = rpc;
      PCS_JMP: sel = jpc;
      default: sel = pc + 32'd4;
    endcase
    npc = sel & WORD_MASK;
  end

endmodule

// File: rtl/ldw_fetch_ctrl.sv
// Fetch controller: IDLE/LOAD/RUN FSM, PC register, fetch counter and the
// shared instruction-memory port between the loader and instruction fetch.
module ldw_fetch_ctrl
  import ldw_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = LDW_RESET_PC,
  parameter int          DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        run,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_gnt,
  output logic [31:0] pc,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  output logic        fetch_valid,
  output logic        flush,
  output logic [31:0] fetch_cnt,
  output logic [1:0]  state
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_cnt_q, fetch_cnt_d;
  logic         ld_gnt_q, ld_gnt_d;
  logic [31:0]  npc;

  ldw_npc_mux u_npc_mux (
    .pc       (pc_q),
    .pcsource (pcsource),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .npc      (npc)
  );

  // State, PC, counter and grant registers with asynchronous reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
      ld_gnt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      ld_gnt_q    <= ld_gnt_d;
    end
  end

  // Next-state logic; the grant is held exactly while the FSM stays in LOAD.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    ld_gnt_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_req) begin
          state_d  = ST_LOAD;
          ld_gnt_d = 1'b1;
        end else if (run) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      ST_LOAD: begin
        if (ld_req) ld_gnt_d = 1'b1;
        else        state_d  = ST_IDLE;
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (!stall) begin
          pc_d        = npc;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-port arbitration and status outputs.
  always_comb begin
    imem_we    = ld_req && ld_gnt_q;
    imem_addr  = pc_q;
    imem_wdata = '0;
    if (state_q == ST_LOAD) begin
      imem_addr  = ld_addr & WORD_MASK;
      imem_wdata = ld_data;
    end
    fetch_valid = (state_q == ST_RUN);
    flush       = (DELAY_SLOT == 0) && (state_q == ST_RUN) && !stall &&
                  (pcsource != PCS_SEQ);
  end

  assign ld_gnt    = ld_gnt_q;
  assign pc        = pc_q;
  assign fetch_cnt = fetch_cnt_q;
  assign state     = state_q;

endmodule
